// File: rtl/seq_rca_if.sv
// seq_rca_if: operand/result/handshake bundle for the seq_rca adder.
// The master drives the operation request; the slave (the adder) returns
// the registered result and the busy/done handshake.
interface seq_rca_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, SUB, A, B, Ci,
    input  S, Co, V, busy, done
  );

  modport slave (
    input  start, SUB, A, B, Ci,
    output S, Co, V, busy, done
  );
endinterface

// File: rtl/seq_rca.sv
// seq_rca: multi-cycle ripple-carry adder/subtractor.
// A single CHUNK-bit adder slice walks across the WIDTH-bit operands, one
// chunk per clock, carrying between chunks through a register. Operands are
// shifted right each cycle so the active chunk always sits in the low bits,
// and the partial sum is filled in from the top. S/Co/V are only written at
// completion, so they never expose partial values.
// Optional feature: define SEQ_RCA_OVF_EN to build the signed-overflow flag V;
// otherwise V is tied low and the overflow logic is not built.
module seq_rca #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_rca_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject operand widths that are not a whole number of chunks.
  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_rca: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             carry_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;

  logic [CHUNK:0]   chunk_sum_s;
  logic [WIDTH-1:0] psum_d;
  logic             last_s;
  logic             accept_s;
  logic             busy_s;
  logic             done_s;

  // New operations are taken only when no operation is running.
  assign accept_s = bus.start && (state_q != ST_RUN);
  assign last_s   = (cnt_q == CW'(N - 1));

  // State register: sequences IDLE -> RUN -> DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: RUN lasts N cycles; DONE may chain straight into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: busy and done follow the registered state directly.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Chunk adder slice and the partial sum with the new chunk inserted at the top.
  always_comb begin
    chunk_sum_s = {1'b0, opa_q[CHUNK-1:0]}
                + {1'b0, opb_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
    psum_d      = (psum_q >> CHUNK)
                | (WIDTH'(chunk_sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Datapath: latch operands on accept, step one chunk per RUN cycle, publish at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + ~borrow_in, so the adder never changes.
      cnt_q   <= '0;
      opa_q   <= bus.A;
      opb_q   <= bus.B ^ {WIDTH{bus.SUB}};
      carry_q <= bus.Ci ^ bus.SUB;
      psum_q  <= '0;
    end else if (state_q == ST_RUN) begin
      opa_q   <= opa_q >> CHUNK;
      opb_q   <= opb_q >> CHUNK;
      carry_q <= chunk_sum_s[CHUNK];
      psum_q  <= psum_d;
      if (last_s) begin
        cnt_q <= '0;
        s_q   <= psum_d;
        co_q  <= chunk_sum_s[CHUNK];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= cnt_q;
    end
  end

`ifdef SEQ_RCA_OVF_EN
  logic v_q;
  logic v_s;

  // On the last chunk the low bits of the shifted operands hold the MSBs.
  always_comb begin
    v_s = (opa_q[CHUNK-1] == opb_q[CHUNK-1]) &&
          (chunk_sum_s[CHUNK-1] != opa_q[CHUNK-1]);
  end

  // Overflow flag registered alongside S at completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if ((state_q == ST_RUN) && last_s && !accept_s) begin
      v_q <= v_s;
    end else begin
      v_q <= v_q;
    end
  end

  assign bus.V = v_q;
`else
  assign bus.V = 1'b0;
`endif

  assign bus.S    = s_q;
  assign bus.Co   = co_q;
  assign bus.busy = busy_s;
  assign bus.done = done_s;

endmodule

// File: tb/tb_seq_rca.sv
// tb_seq_rca: scoreboard bench for seq_rca at WIDTH=8 with CHUNK=1, 4 and 8.
// Stimulus pushes hand-computed results into per-instance queues; monitors
// pop and compare whenever an instance raises done.
module tb_seq_rca;

  localparam int W = 8;
`ifdef SEQ_RCA_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   nchecks;
  int   nerr;
  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  seq_rca_if #(.WIDTH(W)) if1 ();
  seq_rca_if #(.WIDTH(W)) if4 ();
  seq_rca_if #(.WIDTH(W)) if8 ();

  seq_rca #(.WIDTH(W), .CHUNK(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_rca #(.WIDTH(W), .CHUNK(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_rca #(.WIDTH(W), .CHUNK(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_cmp(input string tag, input exp_t got, inout exp_t q[$]);
    exp_t e;
    if (q.size() == 0) begin
      nchecks++;
      nerr++;
      $display("FAIL %s_unexpected_done: got S=%0h with no expected result", tag, got.s);
    end else begin
      e = q.pop_front();
      chk({tag, "_S"}, 32'(got.s), 32'(e.s));
      chk({tag, "_Co"}, 32'(got.co), 32'(e.co));
      chk({tag, "_V"}, 32'(got.v), 32'(e.v));
    end
  endtask

  // Monitors: compare each completion against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && if1.done) mon_cmp("c1", '{if1.S, if1.Co, if1.V}, q1);
    if (rst_n && if4.done) mon_cmp("c4", '{if4.S, if4.Co, if4.V}, q4);
    if (rst_n && if8.done) mon_cmp("c8", '{if8.S, if8.Co, if8.V}, q8);
  end

  task automatic drive(input int sel, input logic st, input logic sub,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    case (sel)
      1: begin if1.start = st; if1.SUB = sub; if1.A = a; if1.B = b; if1.Ci = ci; end
      4: begin if4.start = st; if4.SUB = sub; if4.A = a; if4.B = b; if4.Ci = ci; end
      8: begin if8.start = st; if8.SUB = sub; if8.A = a; if8.B = b; if8.Ci = ci; end
      default: ;
    endcase
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      1: return if1.busy;
      4: return if4.busy;
      8: return if8.busy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      1: return if1.done;
      4: return if4.done;
      8: return if8.done;
      default: return 1'b0;
    endcase
  endfunction

  // One framed operation with latency check; operands are scrambled after accept.
  task automatic run_op(input int sel, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] es, input logic eco, input logic ev,
                        input int exp_lat);
    int n;
    logic seen;
    exp_t e;
    e = '{es, eco, ev};
    case (sel)
      1: q1.push_back(e);
      4: q4.push_back(e);
      8: q8.push_back(e);
      default: ;
    endcase
    drive(sel, 1'b1, sub, a, b, ci);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~sub, W'($urandom), W'($urandom), ~ci);
    chk($sformatf("busy_after_accept_c%0d", sel), 32'(get_busy(sel)), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (get_done(sel)) seen = 1'b1;
    end
    chk($sformatf("latency_c%0d", sel), 32'(n), 32'(exp_lat));
    chk($sformatf("busy_at_done_c%0d", sel), 32'(get_busy(sel)), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("done_one_cycle_c%0d", sel), 32'(get_done(sel)), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic         bsub[3];
    exp_t         bexp[3];
    int           n;
    nchecks = 0;
    nerr    = 0;
    rst_n   = 1'b0;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(8, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_S", 32'(if1.S), 32'h0);
    chk("rst_Co", 32'(if1.Co), 32'h0);
    chk("rst_V", 32'(if1.V), 32'h0);
    chk("rst_busy", 32'(if1.busy), 32'h0);
    chk("rst_done", 32'(if1.done), 32'h0);

    // Bit-serial add and subtract vectors.
    run_op(1, 1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 8);
    run_op(1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8);
    run_op(1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF,  8);
    run_op(1, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 8);
    run_op(1, 1'b1, 8'h07, 8'h05, 1'b1, 8'h01, 1'b1, 1'b0, 8);

    // Reset during the 4th RUN cycle discards the operation.
    drive(1, 1'b1, 1'b0, 8'hAA, 8'h55, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_S", 32'(if1.S), 32'h0);
    chk("midrst_Co", 32'(if1.Co), 32'h0);
    chk("midrst_busy", 32'(if1.busy), 32'h0);
    chk("midrst_done", 32'(if1.done), 32'h0);
    repeat (12) @(posedge clk);
    #1;
    run_op(1, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 8);

    // start held high: each result follows the operands present at its accept edge.
    ba   = '{8'h12, 8'h80, 8'h55};
    bb   = '{8'h34, 8'h80, 8'h0A};
    bsub = '{1'b0, 1'b0, 1'b1};
    bexp = '{'{8'h46, 1'b0, 1'b0}, '{8'h00, 1'b1, OVF}, '{8'h4B, 1'b1, 1'b0}};
    q1.push_back(bexp[0]);
    drive(1, 1'b1, bsub[0], ba[0], bb[0], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, ~bsub[i], W'($urandom), W'($urandom), 1'b1);
      n = 0;
      while (!if1.done && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("b2b_latency_%0d", i), 32'(n), 32'd8);
      if (i < 2) begin
        q1.push_back(bexp[i+1]);
        drive(1, 1'b1, bsub[i+1], ba[i+1], bb[i+1], 1'b0);
      end else begin
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      end
      @(posedge clk); #1;
    end
    chk("b2b_idle_busy", 32'(if1.busy), 32'h0);

    // Wider chunks: same sum, shorter latency.
    run_op(4, 1'b0, 8'h9F, 8'h71, 1'b1, 8'h11, 1'b1, 1'b0, 2);
    run_op(8, 1'b0, 8'h9F, 8'h71, 1'b1, 8'h11, 1'b1, 1'b0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
